unidade_controle_jogada: RTL and testbench
==========================================

Name: unidade_controle_jogada

Overview:
- Control FSM paired with the move datapath: consumes its `tem_jogada` pulse and validity flags, and drives that datapath's clear/enable strobes (`zeraEdge`, `zeraR_macro`, `zeraR_micro`, `registraR_macro`, `registraR_micro`).
- Sequences each turn: macro-cell select, micro-cell select, validate, board write, player swap.
- Enforces a per-selection inactivity timeout and signals end of game.

Parameters:
- TIMEOUT_CICLOS, 5000: cycles waited for a button before a timeout is declared.
- W_TIMER, 13: timer width; must satisfy 2^W_TIMER > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, level, sampled in INICIAL/FIM/TIMEOUT.
- tem_jogada  in  1  one-cycle pulse from datapath edge detector.
- jogada_valida  in  1  datapath: selected micro cell is free (valid in VALIDA).
- macro_livre  in  1  datapath: forced macro (= last micro) still open (valid in TROCA).
- fim_jogo  in  1  datapath: win/draw detected (valid in VERIFICA).
- zeraEdge  out  1  clear edge detector.
- zeraR_macro  out  1  clear macro register.
- zeraR_micro  out  1  clear micro register.
- registraR_macro  out  1  load macro register from buttons.
- registraR_micro  out  1  load micro register from buttons.
- copiaR_macro  out  1  load macro register from micro register (forced macro).
- escreve_tabuleiro  out  1  one-cycle board write strobe.
- jogador  out  1  current player, 0 = X, 1 = O.
- pronto  out  1  game over (FIM).
- timeout  out  1  inactivity timeout (TIMEOUT).
- db_estado  out  4  current state code.

Behaviour:
- Clock, reset and polarity (already decided): one clock; reset is asynchronous and active-low (clock port `clock`, reset port `reset`).
- Reset asserted:
  - state = INICIAL(0), jogador = 0, timer = 0.
  - All strobes 0; pronto = 0; timeout = 0.
  - Takes effect immediately, including mid-turn.
- Outputs:
  - All outputs are Moore, decoded from the state register.
  - jogador is a register, toggled only on exit from TROCA.
- States and transitions:
  - INICIAL(0): iniciar = 1 → PREPARA.
  - PREPARA(1): assert zeraEdge, zeraR_macro, zeraR_micro; jogador ← 0 → ESPERA_MACRO.
  - ESPERA_MACRO(2): timer counts.
    - tem_jogada → REG_MACRO.
    - timer = TIMEOUT_CICLOS-1 → TIMEOUT.
    - If tem_jogada and timer expiry occur in the same cycle, tem_jogada wins.
  - REG_MACRO(3): registraR_macro = 1; clear timer → ESPERA_MICRO.
  - ESPERA_MICRO(4): same rules as ESPERA_MACRO; tem_jogada → REG_MICRO.
  - REG_MICRO(5): registraR_micro = 1 → VALIDA.
  - VALIDA(6):
    - jogada_valida = 1 → ESCREVE.
    - Otherwise clear timer → ESPERA_MICRO; same player, macro retained.
  - ESCREVE(7): escreve_tabuleiro = 1 for exactly one cycle → VERIFICA.
  - VERIFICA(8): fim_jogo = 1 → FIM, else → TROCA.
  - TROCA(9): toggle jogador; clear timer.
    - macro_livre = 1 → COPIA.
    - macro_livre = 0 → ESPERA_MACRO (player chooses a macro).
  - COPIA(10): copiaR_macro = 1 → ESPERA_MICRO.
  - FIM(11): pronto = 1; iniciar → PREPARA.
  - TIMEOUT(12): timeout = 1; iniciar → PREPARA.
  - Codes 13–15 are illegal; they go to INICIAL on the next clock.
- Timer:
  - Increments only in the ESPERA_* states.
  - Cleared in every other state.
  - Saturates; never wraps.
- Latency: tem_jogada at cycle n → register strobe at n+1.
- Stray input: a tem_jogada outside the ESPERA_* states is ignored. It is not queued.
- Strobe exclusivity: registraR_macro, registraR_micro, copiaR_macro and escreve_tabuleiro are mutually exclusive; no two are ever high in the same cycle.

Decomposition:
- Shared package `jogo_pkg` holds:
  - state encoding constants E_INICIAL…E_TIMEOUT (4-bit);
  - JOGADOR_X = 0, JOGADOR_O = 1;
  - TIMEOUT_CICLOS default.
- One sub-module, `contador_timeout`:
  - inputs: clear, enable;
  - output: fim (terminal count);
  - parameterized by TIMEOUT_CICLOS/W_TIMER;
  - reused for the datapath's future display blink timer.

Test Plan:
- Reset during ESPERA_MICRO (db_estado = 4, jogador = 1) → same-cycle db_estado = 0, jogador = 0, all strobes 0.
- Start then full turn:
  - Stimulus: iniciar, tem_jogada, tem_jogada, jogada_valida = 1, fim_jogo = 0, macro_livre = 1.
  - State trace: 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 4.
  - jogador goes 0 → 1 on exit from state 9.
  - escreve_tabuleiro high exactly one cycle.
- Invalid cell: jogada_valida = 0 in VALIDA → back to 4, jogador unchanged, no escreve_tabuleiro pulse.
- Closed forced macro: macro_livre = 0 in TROCA → state 2, copiaR_macro never asserted.
- Timeout, with TIMEOUT_CICLOS = 8:
  - no tem_jogada in ESPERA_MACRO → state 12 after 8 cycles, timeout = 1;
  - tem_jogada on the 8th cycle → state 3 instead (priority).
- End of game: fim_jogo = 1 in VERIFICA → state 11, pronto = 1; a stray tem_jogada is ignored; iniciar → state 1.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes, player encoding and timing defaults shared by the move control path
package jogo_pkg;
  typedef enum logic [3:0] {
    E_INICIAL      = 4'd0,
    E_PREPARA      = 4'd1,
    E_ESPERA_MACRO = 4'd2,
    E_REG_MACRO    = 4'd3,
    E_ESPERA_MICRO = 4'd4,
    E_REG_MICRO    = 4'd5,
    E_VALIDA       = 4'd6,
    E_ESCREVE      = 4'd7,
    E_VERIFICA     = 4'd8,
    E_TROCA        = 4'd9,
    E_COPIA        = 4'd10,
    E_FIM          = 4'd11,
    E_TIMEOUT      = 4'd12
  } estado_t;
  localparam logic JOGADOR_X = 1'b0;
  localparam logic JOGADOR_O = 1'b1;
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
endpackage

// File: rtl/unidade_controle_jogada_if.sv
// unidade_controle_jogada_if: flags and strobes between the move control FSM and its datapath
interface unidade_controle_jogada_if;
  logic iniciar, tem_jogada, jogada_valida, macro_livre, fim_jogo;
  logic zeraEdge, zeraR_macro, zeraR_micro, registraR_macro, registraR_micro;
  logic copiaR_macro, escreve_tabuleiro, jogador, pronto, timeout;
  logic [3:0] db_estado;
  modport master (
    input  iniciar, tem_jogada, jogada_valida, macro_livre, fim_jogo,
    output zeraEdge, zeraR_macro, zeraR_micro, registraR_macro, registraR_micro,
    output copiaR_macro, escreve_tabuleiro, jogador, pronto, timeout, db_estado
  );
  modport slave (
    output iniciar, tem_jogada, jogada_valida, macro_livre, fim_jogo,
    input  zeraEdge, zeraR_macro, zeraR_micro, registraR_macro, registraR_micro,
    input  copiaR_macro, escreve_tabuleiro, jogador, pronto, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogada_contador_timeout.sv
// contador_timeout: saturating inactivity counter, fim high once TIMEOUT_CICLOS-1 is reached
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int W_TIMER        = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);
  localparam logic [W_TIMER-1:0] ULTIMO = W_TIMER'(TIMEOUT_CICLOS - 1);
  logic [W_TIMER-1:0] conta;
  always_ff @(posedge clock or negedge reset)
    if (!reset) conta <= '0;
    else if (clear) conta <= '0;
    else if (enable && conta != ULTIMO) conta <= conta + 1'b1;
  assign fim = conta == ULTIMO;
endmodule

// File: rtl/unidade_controle_jogada.sv
// unidade_controle_jogada: turn sequencing FSM (macro/micro select, validate, write, swap) with timeout
module unidade_controle_jogada
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int W_TIMER        = 13
) (
  input logic clock,
  input logic reset,
  unidade_controle_jogada_if.master jif
);
  estado_t estado, prox;
  logic espera, fim_timer;
  assign espera = estado == E_ESPERA_MACRO || estado == E_ESPERA_MICRO;
  contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS), .W_TIMER(W_TIMER)) u_timer (
    .clock(clock), .reset(reset), .clear(!espera), .enable(espera), .fim(fim_timer)
  );
  // a button press in the same cycle as expiry still counts as a move
  always_comb begin
    prox = E_INICIAL;
    case (estado)
      E_INICIAL:      prox = jif.iniciar ? E_PREPARA : E_INICIAL;
      E_PREPARA:      prox = E_ESPERA_MACRO;
      E_ESPERA_MACRO: prox = jif.tem_jogada ? E_REG_MACRO : fim_timer ? E_TIMEOUT : E_ESPERA_MACRO;
      E_REG_MACRO:    prox = E_ESPERA_MICRO;
      E_ESPERA_MICRO: prox = jif.tem_jogada ? E_REG_MICRO : fim_timer ? E_TIMEOUT : E_ESPERA_MICRO;
      E_REG_MICRO:    prox = E_VALIDA;
      E_VALIDA:       prox = jif.jogada_valida ? E_ESCREVE : E_ESPERA_MICRO;
      E_ESCREVE:      prox = E_VERIFICA;
      E_VERIFICA:     prox = jif.fim_jogo ? E_FIM : E_TROCA;
      E_TROCA:        prox = jif.macro_livre ? E_COPIA : E_ESPERA_MACRO;
      E_COPIA:        prox = E_ESPERA_MICRO;
      E_FIM:          prox = jif.iniciar ? E_PREPARA : E_FIM;
      E_TIMEOUT:      prox = jif.iniciar ? E_PREPARA : E_TIMEOUT;
      default:        prox = E_INICIAL;
    endcase
  end
  // outputs are registered from the next state so they always match the state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado                <= E_INICIAL;
      jif.jogador           <= JOGADOR_X;
      jif.zeraEdge          <= 1'b0;
      jif.zeraR_macro       <= 1'b0;
      jif.zeraR_micro       <= 1'b0;
      jif.registraR_macro   <= 1'b0;
      jif.registraR_micro   <= 1'b0;
      jif.copiaR_macro      <= 1'b0;
      jif.escreve_tabuleiro <= 1'b0;
      jif.pronto            <= 1'b0;
      jif.timeout           <= 1'b0;
    end else begin
      estado                <= prox;
      jif.jogador           <= estado == E_PREPARA ? JOGADOR_X : estado == E_TROCA ? ~jif.jogador : jif.jogador;
      jif.zeraEdge          <= prox == E_PREPARA;
      jif.zeraR_macro       <= prox == E_PREPARA;
      jif.zeraR_micro       <= prox == E_PREPARA;
      jif.registraR_macro   <= prox == E_REG_MACRO;
      jif.registraR_micro   <= prox == E_REG_MICRO;
      jif.copiaR_macro      <= prox == E_COPIA;
      jif.escreve_tabuleiro <= prox == E_ESCREVE;
      jif.pronto            <= prox == E_FIM;
      jif.timeout           <= prox == E_TIMEOUT;
    end
  assign jif.db_estado = estado;
endmodule

// File: tb/tb_unidade_controle_jogada.sv
// tb_unidade_controle_jogada: table-driven turn vectors plus timeout, priority and reset sequences
module tb_unidade_controle_jogada;
  typedef struct packed {
    logic [4:0] in;
    logic [3:0] est;
    logic       jog;
    logic [6:0] str;
    logic       pronto;
    logic       tmo;
  } vec_t;
  localparam logic [4:0] INI = 5'b10000, TEM = 5'b01000, VAL = 5'b00100, LIV = 5'b00010, FIMJ = 5'b00001;
  localparam logic [6:0] S_ZERA = 7'b1110000, S_RM = 7'b0001000, S_RMI = 7'b0000100;
  localparam logic [6:0] S_CP = 7'b0000010, S_ES = 7'b0000001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  unidade_controle_jogada_if jif ();
  logic [6:0] strobes;
  assign strobes = {jif.zeraEdge, jif.zeraR_macro, jif.zeraR_micro, jif.registraR_macro,
                    jif.registraR_micro, jif.copiaR_macro, jif.escreve_tabuleiro};
  unidade_controle_jogada #(.TIMEOUT_CICLOS(8), .W_TIMER(4)) dut (
    .clock(clk), .reset(rst_n), .jif(jif)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic [4:0] in, logic [3:0] est, logic jog, logic [6:0] str,
                             logic pronto = 1'b0, logic tmo = 1'b0);
    return '{in: in, est: est, jog: jog, str: str, pronto: pronto, tmo: tmo};
  endfunction
  task automatic confere(string nome, vec_t e);
    logic [13:0] got, exp;
    got = {jif.db_estado, jif.jogador, strobes, jif.pronto, jif.timeout};
    exp = {e.est, e.jog, e.str, e.pronto, e.tmo};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got est=%0d jog=%b str=%b pronto=%b tmo=%b, expected est=%0d jog=%b str=%b pronto=%b tmo=%b",
               nome, jif.db_estado, jif.jogador, strobes, jif.pronto, jif.timeout,
               e.est, e.jog, e.str, e.pronto, e.tmo);
    end
  endtask
  task automatic aplica(string nome, vec_t e);
    {jif.iniciar, jif.tem_jogada, jif.jogada_valida, jif.macro_livre, jif.fim_jogo} = e.in;
    @(posedge clk);
    #1;
    confere(nome, e);
  endtask
  vec_t tab [30];
  initial begin
    tab = '{
      v(INI, 1, 0, S_ZERA), v(0, 2, 0, 0),       v(TEM, 3, 0, S_RM),   v(0, 4, 0, 0),
      v(TEM, 5, 0, S_RMI),  v(0, 6, 0, 0),       v(VAL, 7, 0, S_ES),   v(0, 8, 0, 0),
      v(0, 9, 0, 0),        v(LIV, 10, 1, S_CP), v(0, 4, 1, 0),        v(TEM, 5, 1, S_RMI),
      v(TEM, 6, 1, 0),      v(0, 4, 1, 0),       v(TEM, 5, 1, S_RMI),  v(0, 6, 1, 0),
      v(VAL, 7, 1, S_ES),   v(0, 8, 1, 0),       v(0, 9, 1, 0),        v(0, 2, 0, 0),
      v(TEM, 3, 0, S_RM),   v(0, 4, 0, 0),       v(TEM, 5, 0, S_RMI),  v(0, 6, 0, 0),
      v(VAL, 7, 0, S_ES),   v(0, 8, 0, 0),       v(FIMJ, 11, 0, 0, 1), v(TEM, 11, 0, 0, 1),
      v(INI, 1, 0, S_ZERA), v(0, 2, 0, 0)
    };
    {jif.iniciar, jif.tem_jogada, jif.jogada_valida, jif.macro_livre, jif.fim_jogo} = '0;
    #12;
    confere("reset_inicial", v(0, 0, 0, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) aplica($sformatf("tabela[%0d]", i), tab[i]);
    for (int i = 0; i < 7; i++) aplica("espera_macro", v(0, 2, 0, 0));
    aplica("timeout_macro", v(0, 12, 0, 0, 0, 1));
    aplica("timeout_parado", v(0, 12, 0, 0, 0, 1));
    aplica("reinicia_timeout", v(INI, 1, 0, S_ZERA));
    aplica("espera_macro_2", v(0, 2, 0, 0));
    for (int i = 0; i < 7; i++) aplica("espera_prioridade", v(0, 2, 0, 0));
    aplica("prioridade_tem_jogada", v(TEM, 3, 0, S_RM));
    aplica("espera_micro", v(0, 4, 0, 0));
    for (int i = 0; i < 7; i++) aplica("espera_micro_cont", v(0, 4, 0, 0));
    aplica("timeout_micro", v(0, 12, 0, 0, 0, 1));
    aplica("reinicia_2", v(INI, 1, 0, S_ZERA));
    aplica("seq_2", v(0, 2, 0, 0));
    aplica("seq_3", v(TEM, 3, 0, S_RM));
    aplica("seq_4", v(0, 4, 0, 0));
    aplica("seq_5", v(TEM, 5, 0, S_RMI));
    aplica("seq_6", v(0, 6, 0, 0));
    aplica("seq_7", v(VAL, 7, 0, S_ES));
    aplica("seq_8", v(0, 8, 0, 0));
    aplica("seq_9", v(0, 9, 0, 0));
    aplica("seq_10", v(LIV, 10, 1, S_CP));
    aplica("seq_4_jog1", v(0, 4, 1, 0));
    {jif.iniciar, jif.tem_jogada, jif.jogada_valida, jif.macro_livre, jif.fim_jogo} = '0;
    #2 rst_n = 1'b0;
    #1 confere("reset_meio_turno", v(0, 0, 0, 0));
    @(posedge clk);
    #1 confere("reset_mantido", v(0, 0, 0, 0));
    rst_n = 1'b1;
    aplica("apos_reset", v(0, 0, 0, 0));
    aplica("inicia_apos_reset", v(INI, 1, 0, S_ZERA));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
